// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect input and decode handoff.
// The fetch unit is the master; memory, branch unit and decode together form the slave side.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        halted;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, halted,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, halted,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        output dec_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited in-order fetch into a small queue,
// with redirect flush, in-flight response dropping and HALT handling.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic           clk,
    input logic           rst_n,
    instr_fetch_if.master bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] HALT_WORD = 32'h0001_0073;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {RUN, HALTING, HALTED} state_t;

    state_t state, state_nxt;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding, outstanding_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];

    logic          fetch_en;
    logic          is_halted;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          rsp_drop;
    logic          enq;
    logic          pop;
    logic          halt_enq;
    logic [31:0]   redirect_target;
    logic [CW-1:0] rsp_one;

    // Queued words plus in-flight requests never exceed DEPTH, so every response has a slot.
    assign credit_used     = {1'b0, outstanding} + {1'b0, q_count};
    assign bus.imem_req_valid = rst_n && fetch_en && !bus.redirect_valid && (credit_used < CREDIT_MAX);
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire        = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_one         = bus.imem_rsp_valid ? ONE : '0;
    assign rsp_drop        = bus.imem_rsp_valid && (drop_cnt != '0);
    assign enq             = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid
                             && (state == RUN);
    assign halt_enq        = enq && (bus.imem_rsp_data == HALT_WORD);
    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

    assign bus.dec_valid   = (q_count != '0) && (state != HALTED);
    assign bus.dec_instr   = instr_q[rd_ptr];
    assign bus.dec_pc      = pc_q[rd_ptr];
    assign pop             = bus.dec_valid && bus.dec_ready;
    assign bus.halted      = is_halted;

    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire && !bus.imem_rsp_valid) begin
            outstanding_nxt = outstanding + ONE;
        end else if (!req_fire && bus.imem_rsp_valid) begin
            outstanding_nxt = outstanding - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.redirect_valid) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (halt_enq) state_nxt = HALTING;
                HALTING: if (pop && (bus.dec_instr == HALT_WORD)) state_nxt = HALTED;
                HALTED:  state_nxt = HALTED;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        fetch_en  = 1'b0;
        is_halted = 1'b0;
        case (state)
            RUN:     fetch_en  = 1'b1;
            HALTED:  is_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_count     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (bus.redirect_valid) begin
                // Everything still in flight belongs to the old path; the one arriving now is discarded here.
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                drop_cnt <= outstanding - rsp_one;
                q_count  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - ONE;
                end else if (halt_enq) begin
                    drop_cnt <= outstanding_nxt;
                end
                if (enq) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                case ({enq, pop})
                    2'b10:   q_count <= q_count + ONE;
                    2'b01:   q_count <= q_count - ONE;
                    default: q_count <= q_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_q[wr_ptr] <= bus.imem_rsp_data;
            pc_q[wr_ptr]    <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-configurable memory model plus logs of
// request and decode handshakes, checked against hand-computed address sequences.
module tb_instr_fetch;
    localparam logic [31:0] HALT   = 32'h0001_0073;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    int          lat = 1;
    logic        halt_en = 1'b0;
    logic [31:0] halt_addr = 32'h0;

    logic [31:0] req_log [$];
    logic [31:0] pop_pc [$];
    logic [31:0] pop_instr [$];
    int          pop_cyc [$];
    pend_t       pend [$];

    int rb, pb, rel_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == halt_addr) return HALT;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l, input logic rdy);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.dec_ready = rdy;
        lat = l;
        tick(2);
        rst_n = 1'b1;
        rb = req_log.size();
        pb = pop_pc.size();
        rel_cyc = cyc;
    endtask

    // Memory: requests seen mid-cycle are answered in order lat cycles later.
    initial begin
        pend_t e;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.imem_req_valid && bus.imem_req_ready) begin
                e.due  = cyc + lat;
                e.addr = bus.imem_req_addr;
                pend.push_back(e);
            end
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) pend.delete();
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.imem_req_valid && bus.imem_req_ready) req_log.push_back(bus.imem_req_addr);
                if (bus.dec_valid && bus.dec_ready) begin
                    pop_pc.push_back(bus.dec_pc);
                    pop_instr.push_back(bus.dec_instr);
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        logic seen;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.dec_ready      = 1'b0;
        rst_n = 1'b0;
        tick(2);
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 0);
        check_eq("rst_dec_valid", 32'(bus.dec_valid), 0);
        check_eq("rst_halted", 32'(bus.halted), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("first_req_valid", 32'(bus.imem_req_valid), 1);
        check_eq("first_req_addr", bus.imem_req_addr, RST_PC);

        // Streaming: one instruction per cycle once the pipe fills.
        do_reset(1, 1'b1);
        tick(12);
        check_eq("s32_npop", 32'(pop_pc.size() - pb >= 8), 1);
        for (int i = 0; i < 8 && pb + i < pop_pc.size(); i++) begin
            check_eq($sformatf("s32_pc%0d", i), pop_pc[pb+i], 32'(4*i));
            check_eq($sformatf("s32_instr%0d", i), pop_instr[pb+i], mem_word(32'(4*i)));
            check_eq($sformatf("s32_cyc%0d", i), 32'(pop_cyc[pb+i] - rel_cyc), 32'(2+i));
        end

        // Decode stall: credit caps requests at DEPTH, order kept on release.
        do_reset(1, 1'b0);
        tick(10);
        check_eq("s33_nreq", 32'(req_log.size() - rb), 4);
        check_eq("s33_npop", 32'(pop_pc.size() - pb), 0);
        check_eq("s33_dec_valid", 32'(bus.dec_valid), 1);
        check_eq("s33_head_pc", bus.dec_pc, 32'h0);
        check_eq("s33_req_valid", 32'(bus.imem_req_valid), 0);
        bus.dec_ready = 1'b1;
        tick(12);
        check_eq("s33_npop2", 32'(pop_pc.size() - pb >= 8), 1);
        for (int i = 0; i < 8 && pb + i < pop_pc.size(); i++) begin
            check_eq($sformatf("s33_pc%0d", i), pop_pc[pb+i], 32'(4*i));
        end

        // Redirect with two requests in flight (latency 2).
        do_reset(2, 1'b1);
        tick(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        @(negedge clk);
        check_eq("s34_req_gated", 32'(bus.imem_req_valid), 0);
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(10);
        check_eq("s34_npop", 32'(pop_pc.size() - pb >= 3), 1);
        check_eq("s34_req_after", req_log[rb+2], 32'h100);
        check_eq("s34_pc0", pop_pc[pb], 32'h100);
        check_eq("s34_instr0", pop_instr[pb], mem_word(32'h100));
        check_eq("s34_pc1", pop_pc[pb+1], 32'h104);
        check_eq("s34_pc2", pop_pc[pb+2], 32'h108);

        // Misaligned redirect target is word-aligned.
        do_reset(1, 1'b1);
        tick(4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        tick(1);
        bus.redirect_valid = 1'b0;
        rb = req_log.size();
        pb = pop_pc.size();
        tick(6);
        check_eq("s35_req0", req_log[rb], 32'h100);
        check_eq("s35_pc0", pop_pc[pb], 32'h100);
        check_eq("s35_pc1", pop_pc[pb+1], 32'h104);

        // HALT at 0x8, then resume via redirect.
        halt_en   = 1'b1;
        halt_addr = 32'h8;
        do_reset(1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.dec_valid && bus.dec_instr == HALT) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("s36_halt_seen", 32'(seen), 1);
        check_eq("s36_halt_pc", bus.dec_pc, 32'h8);
        check_eq("s36_halted_pre", 32'(bus.halted), 0);
        @(negedge clk);
        check_eq("s36_halted", 32'(bus.halted), 1);
        check_eq("s36_dec_valid", 32'(bus.dec_valid), 0);
        check_eq("s36_req_valid", 32'(bus.imem_req_valid), 0);
        tick(5);
        check_eq("s36_nreq", 32'(req_log.size() - rb), 4);
        check_eq("s36_npop", 32'(pop_pc.size() - pb), 3);
        check_eq("s36_last_pop", pop_pc[pb+2], 32'h8);
        check_eq("s36_still_halted", 32'(bus.halted), 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick(1);
        bus.redirect_valid = 1'b0;
        halt_en = 1'b0;
        rb = req_log.size();
        pb = pop_pc.size();
        tick(8);
        check_eq("s36_resume_halted", 32'(bus.halted), 0);
        check_eq("s36_resume_req", req_log[rb], 32'h40);
        check_eq("s36_resume_pc0", pop_pc[pb], 32'h40);
        check_eq("s36_resume_pc1", pop_pc[pb+1], 32'h44);

        // Asynchronous reset with the queue full.
        do_reset(1, 1'b0);
        tick(10);
        check_eq("s37_full_valid", 32'(bus.dec_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s37_async_req", 32'(bus.imem_req_valid), 0);
        check_eq("s37_async_dec", 32'(bus.dec_valid), 0);
        check_eq("s37_async_halted", 32'(bus.halted), 0);
        tick(2);
        rst_n = 1'b1;
        bus.dec_ready = 1'b1;
        rb = req_log.size();
        pb = pop_pc.size();
        @(negedge clk);
        check_eq("s37_refetch_valid", 32'(bus.imem_req_valid), 1);
        check_eq("s37_refetch_addr", bus.imem_req_addr, RST_PC);
        tick(8);
        check_eq("s37_npop", 32'(pop_pc.size() - pb >= 3), 1);
        check_eq("s37_pc0", pop_pc[pb], 32'h0);
        check_eq("s37_pc1", pop_pc[pb+1], 32'h4);
        check_eq("s37_pc2", pop_pc[pb+2], 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
